pipe_id_ex: RTL and testbench

PIPE_ID_EX -- requirements
Module: pipe_id_ex

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_id_ex.sv | 97 +++++++++
 tb/tb_pipe_id_ex.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared ID/EX control layout, bubble constant and action encoding
package pipe_pkg;

  localparam int CTRL_W = 12;

  // MSB-first layout of the packed control word carried from ID to EX
  typedef struct packed {
    logic       rd_sel;
    logic       rd_wena;
    logic       dmem_ena;
    logic       dmem_wena;
    logic [1:0] dmem_type;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_sel;
  } ctrl_t;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } act_t;

  function automatic logic ctrl_rd_wena(input logic [CTRL_W-1:0] ctrl);
    ctrl_t c;
    c = ctrl_t'(ctrl);
    return c.rd_wena;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_id_ex.sv
// rtl/pipe_id_ex.sv - ID/EX pipeline register with hold/flush/stall and perf counters
module pipe_id_ex
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_stall,
  input  logic              in_hold,
  input  logic              in_flush,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_immed,
  input  logic [DATA_W-1:0] in_shamt,
  input  logic [DATA_W-1:0] in_npc,
  input  logic [4:0]        in_rd_waddr,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_immed,
  output logic [DATA_W-1:0] out_shamt,
  output logic [DATA_W-1:0] out_npc,
  output logic [4:0]        out_rd_waddr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_valid,
  output logic [4:0]        out_ex_waddr,
  output logic              out_ex_wena,
  output logic [CNT_W-1:0]  out_bubble_cnt,
  output logic [CNT_W-1:0]  out_inst_cnt
);

  act_t act;

  always_comb begin
    if (in_hold) begin
      act = ACT_HOLD;
    end else if (in_flush || in_stall) begin
      act = ACT_BUBBLE;
    end else begin
      act = ACT_LOAD;
    end
  end

  // Data fields are left untouched on a bubble; only control and rd are scrubbed
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      out_rs_data  <= '0;
      out_rt_data  <= '0;
      out_immed    <= '0;
      out_shamt    <= '0;
      out_npc      <= '0;
      out_rd_waddr <= '0;
      out_ctrl     <= CTRL_BUBBLE;
      out_valid    <= 1'b0;
    end else begin
      case (act)
        ACT_LOAD: begin
          out_rs_data  <= in_rs_data;
          out_rt_data  <= in_rt_data;
          out_immed    <= in_immed;
          out_shamt    <= in_shamt;
          out_npc      <= in_npc;
          out_rd_waddr <= in_rd_waddr;
          out_ctrl     <= in_ctrl;
          out_valid    <= 1'b1;
        end
        ACT_BUBBLE: begin
          out_rd_waddr <= '0;
          out_ctrl     <= CTRL_BUBBLE;
          out_valid    <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_ex_waddr = out_rd_waddr;
  assign out_ex_wena  = out_valid & ctrl_rd_wena(out_ctrl);

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (in_clk),
    .rst_n (in_rst),
    .inc   (act == ACT_BUBBLE),
    .count (out_bubble_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_inst_cnt (
    .clk   (in_clk),
    .rst_n (in_rst),
    .inc   (act == ACT_LOAD),
    .count (out_inst_cnt)
  );

endmodule

// File: tb/tb_pipe_id_ex.sv
// tb/tb_pipe_id_ex.sv - randomized self-checking bench for pipe_id_ex
module tb_pipe_id_ex;

  localparam int DATA_W = 32;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b0;
  logic        in_stall = 1'b0, in_hold = 1'b0, in_flush = 1'b0;
  logic [31:0] in_rs_data = '0, in_rt_data = '0, in_immed = '0, in_shamt = '0, in_npc = '0;
  logic [4:0]  in_rd_waddr = '0;
  logic [11:0] in_ctrl = '0;

  logic [31:0] out_rs_data, out_rt_data, out_immed, out_shamt, out_npc;
  logic [4:0]  out_rd_waddr, out_ex_waddr;
  logic [11:0] out_ctrl;
  logic        out_valid, out_ex_wena;
  logic [31:0] out_bubble_cnt, out_inst_cnt;

  logic [31:0] s_rs_data, s_rt_data, s_immed, s_shamt, s_npc;
  logic [4:0]  s_rd_waddr, s_ex_waddr;
  logic [11:0] s_ctrl;
  logic        s_valid, s_ex_wena;
  logic [3:0]  s_bubble_cnt, s_inst_cnt;

  int checks = 0;
  int errors = 0;

  // reference state
  logic        m_valid;
  logic [11:0] m_ctrl;
  logic [4:0]  m_rd;
  logic [31:0] m_rs, m_rt, m_imm, m_shamt, m_npc;
  longint      m_bub, m_inst, m_inst4;

  always #5 in_clk = ~in_clk;

  pipe_id_ex #(.DATA_W(DATA_W), .CNT_W(32)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_stall(in_stall), .in_hold(in_hold), .in_flush(in_flush),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_immed(in_immed), .in_shamt(in_shamt),
    .in_npc(in_npc), .in_rd_waddr(in_rd_waddr), .in_ctrl(in_ctrl),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_immed(out_immed),
    .out_shamt(out_shamt), .out_npc(out_npc), .out_rd_waddr(out_rd_waddr), .out_ctrl(out_ctrl),
    .out_valid(out_valid), .out_ex_waddr(out_ex_waddr), .out_ex_wena(out_ex_wena),
    .out_bubble_cnt(out_bubble_cnt), .out_inst_cnt(out_inst_cnt)
  );

  pipe_id_ex #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .in_clk(in_clk), .in_rst(in_rst), .in_stall(in_stall), .in_hold(in_hold), .in_flush(in_flush),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_immed(in_immed), .in_shamt(in_shamt),
    .in_npc(in_npc), .in_rd_waddr(in_rd_waddr), .in_ctrl(in_ctrl),
    .out_rs_data(s_rs_data), .out_rt_data(s_rt_data), .out_immed(s_immed),
    .out_shamt(s_shamt), .out_npc(s_npc), .out_rd_waddr(s_rd_waddr), .out_ctrl(s_ctrl),
    .out_valid(s_valid), .out_ex_waddr(s_ex_waddr), .out_ex_wena(s_ex_wena),
    .out_bubble_cnt(s_bubble_cnt), .out_inst_cnt(s_inst_cnt)
  );

  function automatic longint sat(input longint x, input longint max);
    return (x > max) ? max : x;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ctrl = '0; m_rd = '0;
    m_rs = '0; m_rt = '0; m_imm = '0; m_shamt = '0; m_npc = '0;
    m_bub = 0; m_inst = 0; m_inst4 = 0;
  endtask

  task automatic model_edge();
    if (in_hold) return;
    if (in_flush || in_stall) begin
      m_valid = 0; m_ctrl = '0; m_rd = '0;
      m_bub = sat(m_bub + 1, MAX32);
    end else begin
      m_valid = 1; m_ctrl = in_ctrl; m_rd = in_rd_waddr;
      m_rs = in_rs_data; m_rt = in_rt_data; m_imm = in_immed; m_shamt = in_shamt; m_npc = in_npc;
      m_inst = sat(m_inst + 1, MAX32);
      m_inst4 = sat(m_inst4 + 1, MAX4);
    end
  endtask

  task automatic step();
    @(posedge in_clk);
    model_edge();
    #1;
  endtask

  task automatic rand_data();
    in_rs_data = $urandom; in_rt_data = $urandom; in_immed = $urandom;
    in_shamt = 32'($urandom_range(0, 31)); in_npc = $urandom;
    in_rd_waddr = 5'($urandom); in_ctrl = 12'($urandom);
  endtask

  task automatic do_reset();
    in_rst = 1'b0;
    in_hold = 0; in_flush = 0; in_stall = 0;
    #3;
    model_reset();
    @(negedge in_clk);
    in_rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    in_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      in_hold = 1'($urandom); in_flush = 1'($urandom); in_stall = 1'($urandom);
      @(posedge in_clk); #1;
    end
    model_reset();
    checks++;
    if ({out_valid, out_ctrl, out_rd_waddr, out_ex_wena, out_ex_waddr} !== '0 ||
        {out_rs_data, out_rt_data, out_immed, out_shamt, out_npc} !== '0) begin
      errors++; $display("FAIL reset_outputs valid=%0b ctrl=%h rd=%0d rs=%h expected all zero",
                         out_valid, out_ctrl, out_rd_waddr, out_rs_data);
    end
    checks++;
    if (out_bubble_cnt !== 0 || out_inst_cnt !== 0) begin
      errors++; $display("FAIL reset_counters bub=%0d inst=%0d expected 0 0", out_bubble_cnt, out_inst_cnt);
    end
    @(negedge in_clk); in_rst = 1'b1;
    in_hold = 0; in_flush = 0; in_stall = 0;
    rand_data(); in_rd_waddr = 5'd5; in_ctrl = 12'h840;
    step();
    checks++;
    if (out_valid !== m_valid || out_ex_waddr !== m_rd || out_ex_wena !== (m_valid & m_ctrl[10])) begin
      errors++; $display("FAIL first_load valid=%0b waddr=%0d wena=%0b expected %0b %0d %0b",
                         out_valid, out_ex_waddr, out_ex_wena, m_valid, m_rd, m_valid & m_ctrl[10]);
    end
    checks++;
    if (out_inst_cnt !== 32'(m_inst)) begin
      errors++; $display("FAIL first_load_inst_cnt got=%0d expected %0d", out_inst_cnt, m_inst);
    end
  endtask

  task automatic test_stall();
    do_reset();
    rand_data(); in_rd_waddr = 5'd8; in_ctrl = 12'h401;
    step();
    checks++;
    if (out_ex_wena !== 1'b1 || out_ex_waddr !== 5'd8) begin
      errors++; $display("FAIL stall_preload wena=%0b waddr=%0d expected 1 8", out_ex_wena, out_ex_waddr);
    end
    in_stall = 1;
    repeat (2) begin rand_data(); step(); end
    in_stall = 0;
    checks++;
    if (out_valid !== m_valid || out_ex_wena !== 1'b0 || out_ctrl !== m_ctrl || out_rd_waddr !== m_rd) begin
      errors++; $display("FAIL stall_bubble valid=%0b wena=%0b ctrl=%h rd=%0d expected %0b 0 %h %0d",
                         out_valid, out_ex_wena, out_ctrl, out_rd_waddr, m_valid, m_ctrl, m_rd);
    end
    checks++;
    if (out_bubble_cnt !== 32'(m_bub) || out_inst_cnt !== 32'(m_inst)) begin
      errors++; $display("FAIL stall_counters bub=%0d inst=%0d expected %0d %0d",
                         out_bubble_cnt, out_inst_cnt, m_bub, m_inst);
    end
  endtask

  task automatic test_hold_priority();
    do_reset();
    rand_data(); in_ctrl[10] = 1'b1;
    step();
    in_hold = 1; in_stall = 1; in_flush = 1;
    repeat (3) begin rand_data(); step(); end
    in_hold = 0; in_stall = 0; in_flush = 0;
    checks++;
    if (out_valid !== m_valid || out_ctrl !== m_ctrl || out_rd_waddr !== m_rd ||
        out_rs_data !== m_rs || out_npc !== m_npc || out_ex_wena !== 1'b1) begin
      errors++; $display("FAIL hold_outputs valid=%0b ctrl=%h rd=%0d rs=%h expected %0b %h %0d %h",
                         out_valid, out_ctrl, out_rd_waddr, out_rs_data, m_valid, m_ctrl, m_rd, m_rs);
    end
    checks++;
    if (out_bubble_cnt !== 32'(m_bub) || out_inst_cnt !== 32'(m_inst)) begin
      errors++; $display("FAIL hold_counters bub=%0d inst=%0d expected %0d %0d",
                         out_bubble_cnt, out_inst_cnt, m_bub, m_inst);
    end
  endtask

  task automatic test_flush_vs_stall();
    do_reset();
    rand_data(); step();
    in_flush = 1; in_stall = 1; rand_data(); step();
    in_flush = 0; in_stall = 0;
    checks++;
    if (out_bubble_cnt !== 32'(m_bub) || out_valid !== 1'b0 || out_ctrl !== 12'h000) begin
      errors++; $display("FAIL flush_stall bub=%0d valid=%0b ctrl=%h expected %0d 0 000",
                         out_bubble_cnt, out_valid, out_ctrl, m_bub);
    end
  endtask

  task automatic test_rd0_passthrough();
    do_reset();
    rand_data(); in_rd_waddr = 5'd0; in_ctrl[10] = 1'b1;
    step();
    checks++;
    if (out_ex_wena !== 1'b1 || out_ex_waddr !== 5'd0 || out_ctrl !== m_ctrl) begin
      errors++; $display("FAIL rd0_pass wena=%0b waddr=%0d ctrl=%h expected 1 0 %h",
                         out_ex_wena, out_ex_waddr, out_ctrl, m_ctrl);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      rand_data();
      in_hold  = ($urandom_range(0, 99) < 20);
      in_flush = ($urandom_range(0, 99) < 15);
      in_stall = ($urandom_range(0, 99) < 20);
      step();
      checks++;
      if (out_valid !== m_valid || out_ctrl !== m_ctrl || out_rd_waddr !== m_rd ||
          out_ex_waddr !== m_rd || out_ex_wena !== (m_valid & m_ctrl[10])) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d valid=%0b ctrl=%h rd=%0d wena=%0b expected %0b %h %0d %0b",
                           i, out_valid, out_ctrl, out_rd_waddr, out_ex_wena,
                           m_valid, m_ctrl, m_rd, m_valid & m_ctrl[10]);
      end
      if (m_valid) begin
        checks++;
        if (out_rs_data !== m_rs || out_rt_data !== m_rt || out_immed !== m_imm ||
            out_shamt !== m_shamt || out_npc !== m_npc) begin
          errors++; $display("FAIL rand_data cyc=%0d rs=%h rt=%h imm=%h sh=%h npc=%h expected %h %h %h %h %h",
                             i, out_rs_data, out_rt_data, out_immed, out_shamt, out_npc,
                             m_rs, m_rt, m_imm, m_shamt, m_npc);
        end
      end
      checks++;
      if (out_bubble_cnt !== 32'(m_bub) || out_inst_cnt !== 32'(m_inst)) begin
        errors++; $display("FAIL rand_counters cyc=%0d bub=%0d inst=%0d expected %0d %0d",
                           i, out_bubble_cnt, out_inst_cnt, m_bub, m_inst);
      end
    end
    in_hold = 0; in_flush = 0; in_stall = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rand_data(); step();
      if (i == 14) begin
        checks++;
        if (s_inst_cnt !== 4'(m_inst4)) begin
          errors++; $display("FAIL sat_reach_max got=%0d expected %0d", s_inst_cnt, m_inst4);
        end
      end
    end
    checks++;
    if (s_inst_cnt !== 4'(m_inst4)) begin
      errors++; $display("FAIL sat_no_wrap got=%0d expected %0d", s_inst_cnt, m_inst4);
    end
    checks++;
    if (out_inst_cnt !== 32'(m_inst)) begin
      errors++; $display("FAIL sat_wide_cnt got=%0d expected %0d", out_inst_cnt, m_inst);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rand_data(); step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL async_pre valid=%0b expected 1", out_valid);
    end
    #2;
    in_rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== m_valid || out_ctrl !== m_ctrl || out_inst_cnt !== 32'(m_inst)) begin
      errors++; $display("FAIL async_reset valid=%0b ctrl=%h inst=%0d expected 0 000 0",
                         out_valid, out_ctrl, out_inst_cnt);
    end
    @(negedge in_clk); in_rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_hold_priority();
    test_flush_vs_stall();
    test_rd0_passthrough();
    test_random();
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
